seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial bit-sequence detector: the next generation of the lab's fixed-pattern `seq_detector`. It samples one bit per clock from `din` and compares a sliding window against a runtime-loadable pattern of 1..`PAT_W` bits. It pulses `dout` on every match, in either overlapping or non-overlapping mode, and optionally keeps a saturating match counter. It sits directly behind the serial input stage, in the same position as the existing detector.

## Interface
- `PAT_W`, default 8: maximum pattern length in bits (≥2).
- `DEF_PAT`, default 8'b0000_0110: pattern loaded at reset, right-aligned.
- `DEF_LEN`, default 3: pattern length loaded at reset (1..`PAT_W`).
- `CNT_W`, default 8: match counter width.

- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: sample enable; `din` is consumed only when `en`=1.
- `din` in 1: serial data bit.
- `overlap` in 1: 1 = overlapping detection; 0 = non-overlapping detection.
- `cfg_load` in 1: load strobe for `cfg_pattern` and `cfg_len`.
- `cfg_pattern` in `PAT_W`: new pattern, right-aligned. Bit [len-1] is the oldest (first-received) bit.
- `cfg_len` in $clog2(`PAT_W`+1): new pattern length.
- `dout` out 1: match pulse, registered.
- `match_cnt` out `CNT_W`: saturating count of matches.

## Operation
- **State:**
  - `hist[PAT_W-1:0]`: shift register; newest bit enters at bit 0.
  - `fill`: valid-bit count, saturating at `PAT_W`.
  - `pat`, `len`: active configuration.
  - `dout` register.
  - `match_cnt` register.
- **Reset (`rst`=0, asynchronous):** `hist`=0, `fill`=0, `pat`=`DEF_PAT`, `len`=`DEF_LEN`, `dout`=0, `match_cnt`=0.
- **Priority at each edge:** `cfg_load` > `en`.
- **`cfg_load`=1:**
  - Latch `pat`=`cfg_pattern`.
  - Latch `len`=`cfg_len`; `cfg_len`=0 or >`PAT_W` is stored as `PAT_W`.
  - `hist`=0, `fill`=0, `dout`=0. `din` is ignored on that edge. `match_cnt` is held.
- **`en`=0 (no load):** `hist`, `fill` and `match_cnt` are held; `dout`=0.
- **`en`=1 (no load):**
  - hist' = {hist[PAT_W-2:0], din}; fill' = min(fill+1, `PAT_W`).
  - match = (fill' ≥ len) and (hist'[len-1:0] == pat[len-1:0]).
  - dout' = match.
  - On match, `match_cnt` increments, saturating at 2^`CNT_W`−1.
  - On match with `overlap`=0: `fill` is forced to 0 instead of fill'. The matched bits cannot contribute to the next match.
  - On match with `overlap`=1: `fill` takes fill' and the window keeps sliding.
- **Mode change:** `overlap` is sampled every edge. Toggling it mid-stream affects only the decision on that edge and later ones; it causes no flush.
- **`len`=1:** every sampled bit equal to pat[0] is a match, in either mode.

## Timing
- `dout` is a registered, single-cycle pulse. It is high for the cycle after the edge that sampled the final pattern bit (latency 1 clock from `din` sampled to `dout` visible).
- Back-to-back matches give `dout` high on consecutive cycles, with no forced gap.
- `match_cnt` updates on the same edge as `dout`.
- A new configuration takes effect from the edge after `cfg_load`. The first possible match is `len` enabled edges later.
- `rst` assertion mid-stream clears all state immediately, without waiting for a clock edge. Deassertion is expected synchronous to `clk`.

## Configuration
- `SEQ_DET_CNT_EN` defined: the `match_cnt` register and saturating incrementer are built as described.
- `SEQ_DET_CNT_EN` undefined: the counter logic is removed and `match_cnt` is tied to 0. `dout` behaviour is unchanged.

## Test plan
- **Reset defaults:** release `rst`, `en`=1, `overlap`=1, drive 1,1,0,1,1,0 → `dout` pulses after bits 3 and 6; `match_cnt`=2.
- **Overlap vs non-overlap:** `cfg_load` pattern 3'b101, len 3, stream 1,0,1,0,1.
  - `overlap`=1 → pulses after bits 3 and 5; `match_cnt` +2.
  - `overlap`=0 → pulse after bit 3 only; +1.
- **Enable gaps:** pattern 110, `en` dropped for 2 cycles between the second 1 and the 0 → single pulse after the 0 is sampled; `dout` stays 0 during the gap.
- **Config edge cases:**
  - `cfg_len`=0 → `len`=`PAT_W`=8; pattern 8'hA5 fed MSB-first → one pulse after bit 8.
  - `cfg_len`=1, pat[0]=1, stream 1,1,0 → pulses after bits 1 and 2.
- **Saturation and async reset:**
  - `CNT_W`=2, pattern 1 len 1, 5 ones → `match_cnt` sticks at 3.
  - Assert `rst` mid-pattern → `dout`=0, `match_cnt`=0, and `pat` returns to `DEF_PAT` immediately, without a clock edge.
- **Load during stream:** `cfg_load` on the edge that would complete a match → no pulse, `fill`=0, `match_cnt` unchanged.

Source files
------------

// File: rtl/seq_detector_param.sv
// =============================================================================
// seq_detector_param : serial bit-sequence detector with a runtime-loadable
// pattern (1..PAT_W bits), overlapping/non-overlapping modes and optional
// saturating match counter (enabled by defining SEQ_DET_CNT_EN).
// Revision: 1.0
// =============================================================================
`default_nettype none

module seq_detector_param #(
  parameter int               PAT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(3'b110),
  parameter int               DEF_LEN = 3,
  parameter int               CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         din,
  input  logic                         overlap,
  input  logic                         cfg_load,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  output logic                         dout,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int               LEN_W   = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] C_PAT_W = LEN_W'(PAT_W);

  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic             r_dout;

  logic [PAT_W-1:0] w_hist_nxt;
  logic [LEN_W-1:0] w_fill_inc;
  logic [LEN_W-1:0] w_len_cfg;
  logic [PAT_W-1:0] w_mask;
  logic             w_match;

  always_comb begin
    w_hist_nxt = {r_hist[PAT_W-2:0], din};
    w_fill_inc = (r_fill == C_PAT_W) ? r_fill : r_fill + 1'b1;
    w_len_cfg  = ((cfg_len == '0) || (cfg_len > C_PAT_W)) ? C_PAT_W : cfg_len;
    // Shifting by len == PAT_W clears everything, giving an all-ones mask.
    w_mask     = ~({PAT_W{1'b1}} << r_len);
    w_match    = (w_fill_inc >= r_len) && (((w_hist_nxt ^ r_pat) & w_mask) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= DEF_PAT;
      r_len  <= LEN_W'(DEF_LEN);
      r_dout <= 1'b0;
    end else if (cfg_load) begin
      r_pat  <= cfg_pattern;
      r_len  <= w_len_cfg;
      r_hist <= '0;
      r_fill <= '0;
      r_dout <= 1'b0;
    end else if (en) begin
      r_hist <= w_hist_nxt;
      r_dout <= w_match;
      // Non-overlapping mode discards the matched bits from the window.
      r_fill <= (w_match && !overlap) ? '0 : w_fill_inc;
    end else begin
      r_dout <= 1'b0;
    end
  end

  assign dout = r_dout;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!cfg_load && en && w_match && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign match_cnt = r_cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// =============================================================================
// tb_seq_detector_param : directed table-driven bench for seq_detector_param,
// checking a default instance and a CNT_W=2 instance driven in parallel.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_seq_detector_param;

`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct {
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       en;
    logic       din;
    logic       ov;
    logic       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       overlap = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       dout, dout2;
  logic [7:0] cnt;
  logic [1:0] cnt2;

  int nvec = 0;
  int errs = 0;
  int m1 = 0;
  int m2 = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .dout(dout), .match_cnt(cnt)
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .din(din), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .dout(dout2), .match_cnt(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic exp);
    chk({tag, " dout"}, {31'd0, dout}, {31'd0, exp});
    chk({tag, " dout_w2"}, {31'd0, dout2}, {31'd0, exp});
    chk({tag, " cnt"}, {24'd0, cnt}, CNT_ON ? m1 : 0);
    chk({tag, " cnt_w2"}, {30'd0, cnt2}, CNT_ON ? m2 : 0);
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    cfg_load    = v.ld;
    cfg_pattern = v.pat;
    cfg_len     = v.len;
    en          = v.en;
    din         = v.din;
    overlap     = v.ov;
    @(posedge clk);
    #1;
    if (!v.ld && v.exp) begin
      m1 = (m1 == 255) ? 255 : m1 + 1;
      m2 = (m2 == 3) ? 3 : m2 + 1;
    end
    chk_all(tag, v.exp);
  endtask

  task automatic add(input logic e, input logic d, input logic ov, input logic x);
    vec_t v;
    v = '{ld: 1'b0, pat: 8'h00, len: 4'd0, en: e, din: d, ov: ov, exp: x};
    tbl.push_back(v);
  endtask

  task automatic add_ld(input logic [7:0] p, input logic [3:0] l, input logic ov);
    vec_t v;
    v = '{ld: 1'b1, pat: p, len: l, en: 1'b1, din: 1'b1, ov: ov, exp: 1'b0};
    tbl.push_back(v);
  endtask

  task automatic add_bits(input logic [7:0] bits, input logic [7:0] expv, input int n,
                          input logic ov);
    for (int i = n - 1; i >= 0; i--) add(1'b1, bits[i], ov, expv[i]);
  endtask

  initial begin
    // Reset defaults: 110 overlapping, stream 110110.
    add_bits(8'b110110, 8'b001001, 6, 1'b1);
    // 101 overlapping then non-overlapping over 10101.
    add_ld(8'b101, 4'd3, 1'b1);
    add_bits(8'b10101, 8'b00101, 5, 1'b1);
    add_ld(8'b101, 4'd3, 1'b0);
    add_bits(8'b10101, 8'b00100, 5, 1'b0);
    // Enable gap between the second 1 and the 0 of 110.
    add_ld(8'b110, 4'd3, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1);
    // cfg_len 0 and 9 both become a full 8-bit pattern.
    add_ld(8'hA5, 4'd0, 1'b1);
    add_bits(8'hA5, 8'h01, 8, 1'b1);
    add_ld(8'hA5, 4'd9, 1'b1);
    add_bits(8'hA5, 8'h01, 8, 1'b1);
    // Single-bit pattern in both modes, then counter saturation.
    add_ld(8'h01, 4'd1, 1'b1);
    add_bits(8'b110, 8'b110, 3, 1'b1);
    add_bits(8'b11, 8'b11, 2, 1'b0);
    add_bits(8'b11111, 8'b11111, 5, 1'b1);
    // Load on the edge that would complete 110: window and fill restart.
    add_ld(8'b110, 4'd3, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0);
    tbl.push_back('{ld: 1'b1, pat: 8'b000, len: 4'd3, en: 1'b1, din: 1'b0, ov: 1'b1, exp: 1'b0});
    add_bits(8'b000, 8'b001, 3, 1'b1);
    // Mode toggled mid-stream on pattern 000.
    add(1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b1);
    add_bits(8'b000, 8'b001, 3, 1'b0);

    #2;
    chk_all("reset_hold", 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset mid-cycle while dout is high.
    #2;
    rst = 1'b0;
    m1 = 0;
    m2 = 0;
    #1;
    chk_all("async_rst", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    begin
      vec_t v;
      v = '{ld: 1'b0, pat: 8'h00, len: 4'd0, en: 1'b1, din: 1'b1, ov: 1'b1, exp: 1'b0};
      step(v, "post_rst1");
      step(v, "post_rst2");
      v.din = 1'b0;
      v.exp = 1'b1;
      step(v, "post_rst3");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule

`default_nettype wire
